sync_fifo_prog: RTL and testbench
=================================

Name: sync_fifo_prog

Overview:
Single-clock, parametrised FIFO that succeeds the dual-clock FIFO for same-domain buffering.
- Adds occupancy count, programmable almost-full/almost-empty thresholds, synchronous flush, and sticky overflow/underflow error flags.
- Sits between same-clock producer/consumer stages, e.g. between the datapath and the AXI-lite/stream adapters.
- No gray coding or synchronisers are needed.

Parameters:
- DATA_WIDTH, 16, width of each data word.
- FIFO_DEPTH, 8, number of entries; power of two, >= 2 (elaboration-time assertion).
- AFULL_THRESH, FIFO_DEPTH-2, almost_full asserts when count >= AFULL_THRESH; legal range 1..FIFO_DEPTH.
- AEMPTY_THRESH, 2, almost_empty asserts when count <= AEMPTY_THRESH; legal range 0..FIFO_DEPTH-1.

Ports:
- clk  input  1  single clock; all logic on posedge.
- rst_n  input  1  asynchronous, active-low reset.
- wr_en  input  1  write request.
- data_in  input  DATA_WIDTH  write data.
- rd_en  input  1  read request (pop).
- flush  input  1  synchronous clear of contents.
- clr_err  input  1  clears sticky error flags.
- data_out  output  DATA_WIDTH  read data.
- full  output  1  count == FIFO_DEPTH.
- empty  output  1  count == 0.
- almost_full  output  1  count >= AFULL_THRESH.
- almost_empty  output  1  count <= AEMPTY_THRESH.
- count  output  $clog2(FIFO_DEPTH)+1  current occupancy, 0..FIFO_DEPTH.
- overflow  output  1  sticky: a write was attempted while full.
- underflow  output  1  sticky: a read was attempted while empty.

Behaviour:
- Reset (rst_n low, asynchronous):
  - wr_ptr, rd_ptr and count go to 0.
  - data_out, overflow and underflow go to 0.
  - Therefore empty=1, full=0, almost_empty=1, and almost_full=(AFULL_THRESH==0 ? 1 : 0), which is effectively 0.
  - Memory contents are not reset.
  - Reset mid-operation discards all stored data; the first write after rst_n rises is the first word read.
- Write accept: wr_ok = wr_en & ~full & ~flush. When accepted, mem[wr_ptr] <= data_in and wr_ptr increments, wrapping modulo FIFO_DEPTH.
- Read accept: rd_ok = rd_en & ~empty & ~flush. When accepted, rd_ptr increments, wrapping modulo FIFO_DEPTH.
- Read accept and write accept are evaluated against the current (registered) full/empty state:
  - A write when full is rejected even if a read occurs in the same cycle.
  - A read when empty is rejected even if a write occurs in the same cycle.
- Count update:
  - count <= count + wr_ok - rd_ok.
  - Simultaneous accepted read and write leave count unchanged.
  - Pointers carry no extra wrap bit; count alone decides full/empty.
- Status outputs: all flags are combinational decodes of registered count only, with no input-to-flag paths.
- Read latency (default build):
  - data_out <= mem[rd_ptr] on the edge where rd_ok=1, so data is valid 1 cycle after rd_en.
  - data_out holds its value when there is no accepted read.
- Flush:
  - Highest priority after reset.
  - Sets wr_ptr, rd_ptr and count to 0 next cycle.
  - data_out and error flags are unchanged.
  - Ignores wr_en and rd_en in that cycle, with no error flagging.
- Error flags:
  - overflow is set when wr_en & full & ~flush.
  - underflow is set when rd_en & empty & ~flush.
  - Both are cleared by clr_err.
  - Set wins over clear in the same cycle.

Optional Feature:
- Macro: SYNC_FIFO_FWFT_EN.
- When defined (first-word-fall-through):
  - data_out = mem[rd_ptr] combinationally.
  - The head word is visible whenever empty=0; rd_en acknowledges and pops it.
  - data_out is don't-care while empty.
  - The registered data_out flop is removed.
- When undefined: the registered 1-cycle read latency described above applies.
- Flags, count and error behaviour are identical in both modes.

Decomposition:
- Package fifo_pkg:
  - Localparam helper function for the pointer width, clog2 of depth.
  - Typedef fifo_status_t, a packed struct of full, empty, almost_full, almost_empty, overflow and underflow, reused by future FIFO variants.
- One sub-module: fifo_ram_sp2 (simple dual-port register array).
  - Write port: clk, we, waddr, wdata.
  - Asynchronous read port: raddr, rdata.
  - Parameters: DATA_WIDTH and FIFO_DEPTH.

Test Plan:
1. Reset, then 8 writes 0x0001..0x0008 with no reads -> count=8, full=1, almost_full=1 from count=6; a 9th write 0xDEAD sets overflow=1 and count stays 8.
2. From full, 8 reads -> data_out sequence 0x0001..0x0008 (1-cycle latency, or immediately in FWFT); empty=1 after the last read; a further rd_en sets underflow=1 and data_out holds 0x0008.
3. Steady state with count=4 and wr_en=rd_en=1 for 20 cycles (incrementing data) -> count stays 4, data order preserved across pointer wrap, no error flags.
4. Empty FIFO with simultaneous wr_en=rd_en=1 -> write accepted, read rejected, underflow=1, count=1; full FIFO with both -> read accepted, write rejected, overflow=1, count=7.
5. count=5 then flush=1 with wr_en=1 -> next cycle count=0, empty=1, no overflow; next write 0x00AA is read back first.
6. rst_n pulsed low asynchronously mid-burst (count=3) -> all outputs go to reset values immediately, without waiting for a clock edge; clr_err asserted together with a new overflow event leaves overflow=1.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared FIFO definitions.
//   ptr_width()   : address width needed to index a FIFO of the given depth
//   fifo_status_t : packed status flags, reused by other FIFO variants
package fifo_pkg;

  function automatic int unsigned ptr_width(input int unsigned depth);
    return (depth <= 1) ? 1 : $clog2(depth);
  endfunction

  typedef struct packed {
    logic full;
    logic empty;
    logic almost_full;
    logic almost_empty;
    logic overflow;
    logic underflow;
  } fifo_status_t;

endpackage

// File: rtl/fifo_ram_sp2.sv
// Simple dual-port register array: one synchronous write port and one
// asynchronous read port. Contents are not reset.
//   clk   : write clock
//   we    : write enable
//   waddr : write address
//   wdata : write data
//   raddr : read address
//   rdata : read data (combinational from raddr)
module fifo_ram_sp2 #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic                                   clk,
  input  logic                                   we,
  input  logic [fifo_pkg::ptr_width(FIFO_DEPTH)-1:0] waddr,
  input  logic [DATA_WIDTH-1:0]                  wdata,
  input  logic [fifo_pkg::ptr_width(FIFO_DEPTH)-1:0] raddr,
  output logic [DATA_WIDTH-1:0]                  rdata
);
  import fifo_pkg::*;

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo_prog.sv
// Single-clock FIFO with occupancy count, programmable almost-full /
// almost-empty thresholds, synchronous flush and sticky error flags.
// Optional macro SYNC_FIFO_FWFT_EN selects first-word-fall-through output
// (data_out shows the head word combinationally); otherwise data_out is a
// register loaded on each accepted read (1-cycle latency).
//   clk, rst_n   : clock, asynchronous active-low reset
//   wr_en/data_in: write request and data
//   rd_en        : read request (pop)
//   flush        : synchronous clear of contents
//   clr_err      : clears overflow/underflow
//   data_out     : read data
//   full, empty, almost_full, almost_empty, count : occupancy status
//   overflow/underflow : sticky error flags
module sync_fifo_prog #(
  parameter int unsigned DATA_WIDTH    = 16,
  parameter int unsigned FIFO_DEPTH    = 8,
  parameter int unsigned AFULL_THRESH  = FIFO_DEPTH - 2,
  parameter int unsigned AEMPTY_THRESH = 2
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        wr_en,
  input  logic [DATA_WIDTH-1:0]       data_in,
  input  logic                        rd_en,
  input  logic                        flush,
  input  logic                        clr_err,
  output logic [DATA_WIDTH-1:0]       data_out,
  output logic                        full,
  output logic                        empty,
  output logic                        almost_full,
  output logic                        almost_empty,
  output logic [$clog2(FIFO_DEPTH):0] count,
  output logic                        overflow,
  output logic                        underflow
);
  import fifo_pkg::*;

  localparam int unsigned PW = ptr_width(FIFO_DEPTH);
  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_depth_chk
    $error("sync_fifo_prog: FIFO_DEPTH must be a power of two >= 2");
  end
  if ((AFULL_THRESH < 1) || (AFULL_THRESH > FIFO_DEPTH)) begin : g_afull_chk
    $error("sync_fifo_prog: AFULL_THRESH out of range 1..FIFO_DEPTH");
  end
  if (AEMPTY_THRESH > FIFO_DEPTH - 1) begin : g_aempty_chk
    $error("sync_fifo_prog: AEMPTY_THRESH out of range 0..FIFO_DEPTH-1");
  end

  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [CW-1:0]         count_q;
  logic                  overflow_q;
  logic                  underflow_q;
  logic                  wr_ok;
  logic                  rd_ok;
  logic                  ovf_set;
  logic                  unf_set;
  logic [DATA_WIDTH-1:0] ram_rdata;
  fifo_status_t          status;

  // Status is decoded from registered state only; no input reaches a flag.
  always_comb begin
    status              = '0;
    status.full         = (count_q == CW'(FIFO_DEPTH));
    status.empty        = (count_q == '0);
    status.almost_full  = (count_q >= CW'(AFULL_THRESH));
    status.almost_empty = (count_q <= CW'(AEMPTY_THRESH));
    status.overflow     = overflow_q;
    status.underflow    = underflow_q;
  end

  assign wr_ok   = wr_en & ~status.full  & ~flush;
  assign rd_ok   = rd_en & ~status.empty & ~flush;
  assign ovf_set = wr_en &  status.full  & ~flush;
  assign unf_set = rd_en &  status.empty & ~flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else if (flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + PW'(1);
      if (rd_ok) rd_ptr <= rd_ptr + PW'(1);
      count_q <= count_q + CW'(wr_ok) - CW'(rd_ok);
    end
  end

  // Set takes priority over clr_err in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (ovf_set)      overflow_q  <= 1'b1;
      else if (clr_err) overflow_q  <= 1'b0;
      if (unf_set)      underflow_q <= 1'b1;
      else if (clr_err) underflow_q <= 1'b0;
    end
  end

  fifo_ram_sp2 #(
    .DATA_WIDTH (DATA_WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_ram (
    .clk   (clk),
    .we    (wr_ok),
    .waddr (wr_ptr),
    .wdata (data_in),
    .raddr (rd_ptr),
    .rdata (ram_rdata)
  );

`ifdef SYNC_FIFO_FWFT_EN
  assign data_out = ram_rdata;
`else
  logic [DATA_WIDTH-1:0] data_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     data_q <= '0;
    else if (rd_ok) data_q <= ram_rdata;
  end

  assign data_out = data_q;
`endif

  assign full         = status.full;
  assign empty        = status.empty;
  assign almost_full  = status.almost_full;
  assign almost_empty = status.almost_empty;
  assign count        = count_q;
  assign overflow     = status.overflow;
  assign underflow    = status.underflow;

endmodule

// File: tb/tb_sync_fifo_prog.sv
// Directed, table-driven bench for sync_fifo_prog (registered-read build).
module tb_sync_fifo_prog;

  localparam int DW    = 16;
  localparam int DEPTH = 8;
  localparam int AF    = 6;
  localparam int AE    = 2;

  logic          clk;
  logic          rst_n;
  logic          wr_en;
  logic [DW-1:0] data_in;
  logic          rd_en;
  logic          flush;
  logic          clr_err;
  logic [DW-1:0] data_out;
  logic          full;
  logic          empty;
  logic          almost_full;
  logic          almost_empty;
  logic [3:0]    count;
  logic          overflow;
  logic          underflow;

  int errors = 0;
  int checks = 0;

  sync_fifo_prog #(
    .DATA_WIDTH    (DW),
    .FIFO_DEPTH    (DEPTH),
    .AFULL_THRESH  (AF),
    .AEMPTY_THRESH (AE)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .wr_en        (wr_en),
    .data_in      (data_in),
    .rd_en        (rd_en),
    .flush        (flush),
    .clr_err      (clr_err),
    .data_out     (data_out),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .count        (count),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          wr;
    logic [DW-1:0] din;
    logic          rd;
    logic          fl;
    logic          clr;
    int            cnt;
    logic          ovf;
    logic          unf;
    logic          chkd;
    logic [DW-1:0] dout;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input logic wr, input logic [DW-1:0] din,
                              input logic rd, input logic fl, input logic clr,
                              input int cnt, input logic ovf, input logic unf,
                              input logic chkd, input logic [DW-1:0] dout);
    vec_t v;
    v = '{wr, din, rd, fl, clr, cnt, ovf, unf, chkd, dout};
    tbl.push_back(v);
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Flags are checked against their definitions in terms of the expected count.
  task automatic chk_state(input string tag, input int cnt, input logic ovf,
                           input logic unf, input logic chkd, input logic [DW-1:0] dout);
    chk({tag, " count"}, int'(count), cnt);
    chk({tag, " full"}, int'(full), int'(cnt == DEPTH));
    chk({tag, " empty"}, int'(empty), int'(cnt == 0));
    chk({tag, " almost_full"}, int'(almost_full), int'(cnt >= AF));
    chk({tag, " almost_empty"}, int'(almost_empty), int'(cnt <= AE));
    chk({tag, " overflow"}, int'(overflow), int'(ovf));
    chk({tag, " underflow"}, int'(underflow), int'(unf));
    if (chkd) chk({tag, " data_out"}, int'(data_out), int'(dout));
  endtask

  task automatic step(input string tag, input vec_t v);
    @(negedge clk);
    wr_en   = v.wr;
    data_in = v.din;
    rd_en   = v.rd;
    flush   = v.fl;
    clr_err = v.clr;
    @(posedge clk);
    #1;
    chk_state(tag, v.cnt, v.ovf, v.unf, v.chkd, v.dout);
  endtask

  initial begin
    vec_t v;
    wr_en = 0; data_in = '0; rd_en = 0; flush = 0; clr_err = 0;
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1;
    chk_state("reset", 0, 0, 0, 1, 16'h0000);
    @(negedge clk);
    rst_n = 1;

    // 1: fill, then overflow on a ninth write
    for (int i = 1; i <= 8; i++) add(1, 16'(i), 0, 0, 0, i, 0, 0, 1, 16'h0000);
    add(1, 16'hDEAD, 0, 0, 0, 8, 1, 0, 1, 16'h0000);
    // 2: drain in order, then underflow with data_out held
    for (int i = 1; i <= 8; i++) add(0, '0, 1, 0, 0, 8 - i, 1, 0, 1, 16'(i));
    add(0, '0, 1, 0, 0, 0, 1, 1, 1, 16'h0008);
    add(0, '0, 0, 0, 1, 0, 0, 0, 1, 16'h0008);
    // 3: count=4 steady state across pointer wrap
    for (int i = 0; i < 4; i++) add(1, 16'(16'h10 + i), 0, 0, 0, i + 1, 0, 0, 1, 16'h0008);
    for (int i = 0; i < 20; i++) add(1, 16'(16'h14 + i), 1, 0, 0, 4, 0, 0, 1, 16'(16'h10 + i));
    for (int i = 0; i < 4; i++) add(0, '0, 1, 0, 0, 3 - i, 0, 0, 1, 16'(16'h24 + i));
    // 4: simultaneous read/write on empty, then on full
    add(1, 16'h0030, 1, 0, 0, 1, 0, 1, 1, 16'h0027);
    add(0, '0, 0, 0, 1, 1, 0, 0, 1, 16'h0027);
    for (int i = 1; i <= 7; i++) add(1, 16'(16'h30 + i), 0, 0, 0, i + 1, 0, 0, 1, 16'h0027);
    add(1, 16'h0099, 1, 0, 0, 7, 1, 0, 1, 16'h0030);
    add(0, '0, 0, 0, 1, 7, 0, 0, 1, 16'h0030);
    // 5: flush with a concurrent write
    add(0, '0, 1, 0, 0, 6, 0, 0, 1, 16'h0031);
    add(0, '0, 1, 0, 0, 5, 0, 0, 1, 16'h0032);
    add(1, 16'h0055, 0, 1, 0, 0, 0, 0, 1, 16'h0032);
    add(1, 16'h00AA, 0, 0, 0, 1, 0, 0, 1, 16'h0032);
    add(0, '0, 1, 0, 0, 0, 0, 0, 1, 16'h00AA);
    // set underflow, then three words ahead of the asynchronous reset
    add(0, '0, 1, 0, 0, 0, 0, 1, 1, 16'h00AA);
    for (int i = 1; i <= 3; i++) add(1, 16'(16'h60 + i), 0, 0, 0, i, 0, 1, 1, 16'h00AA);

    for (int i = 0; i < tbl.size(); i++) step($sformatf("vec%0d", i), tbl[i]);

    // 6: asynchronous reset between clock edges
    @(negedge clk);
    wr_en = 0; rd_en = 0; clr_err = 0; flush = 0;
    #2 rst_n = 0;
    #1;
    chk_state("async_rst", 0, 0, 0, 1, 16'h0000);
    #1 rst_n = 1;

    v = '{1, 16'h0071, 0, 0, 0, 1, 0, 0, 1, 16'h0000};
    step("post_rst_wr", v);
    v = '{0, 16'h0000, 1, 0, 0, 0, 0, 0, 1, 16'h0071};
    step("post_rst_rd", v);
    for (int i = 1; i <= 8; i++) begin
      v = '{1, 16'(16'h80 + i), 0, 0, 0, i, 0, 0, 1, 16'h0071};
      step("refill", v);
    end
    v = '{1, 16'h00EE, 0, 0, 1, 8, 1, 0, 1, 16'h0071};
    step("set_vs_clr", v);

    @(negedge clk);
    wr_en = 0; rd_en = 0; clr_err = 0; flush = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
